// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with direct writes and a two-edge multiply-accumulate
// style add/subtract into the full {HI,LO} value.
module hilo_acc_unit #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [2*DW-1:0] wdata,
    input  logic            rd_sel,
    input  logic            rd_en,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic [2*DW-1:0] hilo
);

    localparam logic [2:0] OP_WR      = 3'd1;
    localparam logic [2:0] OP_MTHI    = 3'd2;
    localparam logic [2:0] OP_MTLO    = 3'd3;
    localparam logic [2:0] OP_ACC_ADD = 3'd4;
    localparam logic [2:0] OP_ACC_SUB = 3'd5;

    typedef enum logic {IDLE, ACC} state_t;

    state_t          state;
    logic [2*DW-1:0] opnd_p0;
    logic            sub_p0;
    logic            accept;

    // Wraps modulo 2^(2*DW); no overflow indication is kept.
    function automatic logic [2*DW-1:0] acc_result(input logic [2*DW-1:0] cur,
                                                   input logic [2*DW-1:0] opnd,
                                                   input logic            sub);
        acc_result = sub ? (cur - opnd) : (cur + opnd);
    endfunction

    assign accept = op_valid && !busy && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            hilo    <= '0;
            opnd_p0 <= '0;
            sub_p0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_WR:   hilo <= wdata;
                            OP_MTHI: hilo[2*DW-1:DW] <= wdata[DW-1:0];
                            OP_MTLO: hilo[DW-1:0] <= wdata[DW-1:0];
                            OP_ACC_ADD, OP_ACC_SUB: begin
                                opnd_p0 <= wdata;
                                sub_p0  <= (op == OP_ACC_SUB);
                                state   <= ACC;
                                busy    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                // Stage p0 -> architectural commit; flush drops the pending result.
                ACC: begin
                    if (!flush) begin
                        hilo <= acc_result(hilo, opnd_p0, sub_p0);
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            rdata = rd_sel ? hilo[2*DW-1:DW] : hilo[DW-1:0];
        end
    end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Randomized plus directed bench for hilo_acc_unit against a behavioural
// model of the committed {HI,LO} value and the pending accumulate.
module tb_hilo_acc_unit;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst, flush, op_valid, rd_sel, rd_en;
    logic [2:0]      op;
    logic [2*DW-1:0] wdata;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [2*DW-1:0] hilo;

    hilo_acc_unit #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
        .wdata(wdata), .rd_sel(rd_sel), .rd_en(rd_en), .rdata(rdata),
        .busy(busy), .hilo(hilo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: committed value, and whether an accumulate is waiting.
    logic [2*DW-1:0] m_hilo;
    bit              m_busy;
    logic [2*DW-1:0] m_pend;
    bit              m_sub;
    bit              m_valid = 0;

    task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: predict next model state from the presented inputs.
    task automatic tick();
        logic [2*DW-1:0] h;
        bit b;
        h = m_hilo;
        b = m_busy;
        if (rst) begin
            h = '0; b = 0;
        end else if (m_busy) begin
            if (!flush) h = m_sub ? (m_hilo - m_pend) : (m_hilo + m_pend);
            b = 0;
        end else if (op_valid && !flush) begin
            case (op)
                3'd1: h = wdata;
                3'd2: h = {wdata[DW-1:0], m_hilo[DW-1:0]};
                3'd3: h = {m_hilo[2*DW-1:DW], wdata[DW-1:0]};
                3'd4, 3'd5: begin
                    b = 1; m_pend = wdata; m_sub = (op == 3'd5);
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        m_hilo  = h;
        m_busy  = b;
        m_valid = 1;
    endtask

    task automatic drv(input bit ov, input logic [2:0] o, input logic [2*DW-1:0] wd,
                       input bit fl, input bit r);
        op_valid = ov; op = o; wdata = wd; flush = fl; rst = r;
        tick();
        op_valid = 0; flush = 0; rst = 0;
    endtask

    // Continuous comparison away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("hilo", hilo, m_hilo);
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("rdata", {32'd0, rdata},
                {32'd0, rd_en ? (rd_sel ? m_hilo[2*DW-1:DW] : m_hilo[DW-1:0]) : 32'd0});
        end
    end

    initial begin
        rst = 1; flush = 0; op_valid = 0; op = 3'd0; wdata = '0; rd_sel = 0; rd_en = 0;
        drv(0, 3'd0, '0, 0, 1);

        rd_en = 1; rd_sel = 0; #1;
        chk("reset_rdata_lo", {32'd0, rdata}, 64'd0);
        rd_sel = 1; #1;
        chk("reset_rdata_hi", {32'd0, rdata}, 64'd0);
        chk("reset_hilo", hilo, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);

        drv(1, 3'd1, 64'h00000001_FFFFFFFF, 0, 0);
        drv(1, 3'd2, 64'h00000000_AAAA5555, 0, 0);
        chk("mthi", hilo, 64'hAAAA5555_FFFFFFFF);
        drv(1, 3'd3, 64'h00000000_12345678, 0, 0);
        chk("mtlo", hilo, 64'hAAAA5555_12345678);

        drv(1, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 0, 0);
        drv(1, 3'd4, 64'h1, 0, 0);
        chk("acc_busy", {63'd0, busy}, 64'd1);
        chk("acc_no_early_commit", hilo, 64'hFFFFFFFF_FFFFFFFF);
        drv(0, 3'd0, '0, 0, 0);
        chk("acc_add_wrap", hilo, 64'd0);
        chk("acc_busy_clear", {63'd0, busy}, 64'd0);
        drv(1, 3'd5, 64'h1, 0, 0);
        drv(0, 3'd0, '0, 0, 0);
        chk("acc_sub_wrap", hilo, 64'hFFFFFFFF_FFFFFFFF);

        drv(1, 3'd4, 64'h2, 0, 0);
        drv(1, 3'd1, 64'h1234, 0, 0);
        chk("wr_during_busy", hilo, 64'h1);
        chk("busy_after_2", {63'd0, busy}, 64'd0);

        drv(1, 3'd1, 64'h10, 0, 0);
        drv(1, 3'd4, 64'h5, 0, 0);
        drv(0, 3'd0, '0, 1, 0);
        chk("flush_acc", hilo, 64'h10);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        drv(1, 3'd1, 64'h99, 1, 0);
        chk("flush_idle_wr", hilo, 64'h10);

        drv(1, 3'd4, 64'h7, 0, 0);
        drv(1, 3'd1, 64'h55, 0, 1);
        chk("rst_in_busy", hilo, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [2*DW-1:0] wd;
            case ($urandom_range(0, 3))
                0: wd = 64'hFFFFFFFF_FFFFFFFF;
                1: wd = 64'($urandom_range(0, 3));
                default: wd = {$urandom, $urandom};
            endcase
            rd_en  = 1'($urandom);
            rd_sel = 1'($urandom);
            drv(1'($urandom_range(0, 3) != 0), 3'($urandom), wd,
                $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
